// File: rtl/cls_compare_unit.sv
`default_nettype none
// ============================================================================
// Module   : cls_compare_unit
// Purpose  : Lockstep comparator for a master core and two shadow cores;
//            raises a sticky fault flag one cycle after any divergence.
// Revision : 1.0 - initial release
// ============================================================================
module cls_compare_unit (
    input  logic        clk,
    input  logic        rst,
    output logic        fault,

    input  logic        instr_req_ms,
    input  logic [31:0] instr_addr_ms,
    input  logic        data_req_ms,
    input  logic        data_we_ms,
    input  logic [3:0]  data_be_ms,
    input  logic [31:0] data_addr_ms,
    input  logic [31:0] data_wdata_ms,
    input  logic        core_busy_ms,

    input  logic        instr_req_sl1,
    input  logic [31:0] instr_addr_sl1,
    input  logic        data_req_sl1,
    input  logic        data_we_sl1,
    input  logic [3:0]  data_be_sl1,
    input  logic [31:0] data_addr_sl1,
    input  logic [31:0] data_wdata_sl1,
    input  logic        core_busy_sl1,

    input  logic        instr_req_sl2,
    input  logic [31:0] instr_addr_sl2,
    input  logic        data_req_sl2,
    input  logic        data_we_sl2,
    input  logic [3:0]  data_be_sl2,
    input  logic [31:0] data_addr_sl2,
    input  logic [31:0] data_wdata_sl2,
    input  logic        core_busy_sl2
);

    logic w_instr_req_diff;
    logic w_data_req_diff;
    logic w_core_busy_diff;
    logic w_instr_addr_diff;
    logic w_data_ctrl_diff;
    logic w_data_wdata_diff;
    logic w_mis;
    logic r_fault;

    assign w_instr_req_diff  = (instr_req_ms  != instr_req_sl1)  | (instr_req_ms  != instr_req_sl2);
    assign w_data_req_diff   = (data_req_ms   != data_req_sl1)   | (data_req_ms   != data_req_sl2);
    assign w_core_busy_diff  = (core_busy_ms  != core_busy_sl1)  | (core_busy_ms  != core_busy_sl2);
    assign w_instr_addr_diff = (instr_addr_ms != instr_addr_sl1) | (instr_addr_ms != instr_addr_sl2);

    assign w_data_ctrl_diff  = (data_addr_ms != data_addr_sl1) | (data_addr_ms != data_addr_sl2)
                             | (data_we_ms   != data_we_sl1)   | (data_we_ms   != data_we_sl2)
                             | (data_be_ms   != data_be_sl1)   | (data_be_ms   != data_be_sl2);

    assign w_data_wdata_diff = (data_wdata_ms != data_wdata_sl1) | (data_wdata_ms != data_wdata_sl2);

    // Address/data fields are don't-care unless the master is actually requesting.
    assign w_mis = w_instr_req_diff
                 | w_data_req_diff
                 | w_core_busy_diff
                 | (instr_req_ms & w_instr_addr_diff)
                 | (data_req_ms  & w_data_ctrl_diff)
                 | (data_req_ms  & data_we_ms & w_data_wdata_diff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= r_fault | w_mis;
        end
    end

    assign fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_cls_compare_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cls_compare_unit
// Purpose  : Directed self-checking bench for the lockstep comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cls_compare_unit;

    logic        clk;
    logic        rst;
    logic        fault;

    logic        instr_req_ms,  instr_req_sl1,  instr_req_sl2;
    logic [31:0] instr_addr_ms, instr_addr_sl1, instr_addr_sl2;
    logic        data_req_ms,   data_req_sl1,   data_req_sl2;
    logic        data_we_ms,    data_we_sl1,    data_we_sl2;
    logic [3:0]  data_be_ms,    data_be_sl1,    data_be_sl2;
    logic [31:0] data_addr_ms,  data_addr_sl1,  data_addr_sl2;
    logic [31:0] data_wdata_ms, data_wdata_sl1, data_wdata_sl2;
    logic        core_busy_ms,  core_busy_sl1,  core_busy_sl2;

    int n_tests;
    int n_fail;

    cls_compare_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fault          (fault),
        .instr_req_ms   (instr_req_ms),
        .instr_addr_ms  (instr_addr_ms),
        .data_req_ms    (data_req_ms),
        .data_we_ms     (data_we_ms),
        .data_be_ms     (data_be_ms),
        .data_addr_ms   (data_addr_ms),
        .data_wdata_ms  (data_wdata_ms),
        .core_busy_ms   (core_busy_ms),
        .instr_req_sl1  (instr_req_sl1),
        .instr_addr_sl1 (instr_addr_sl1),
        .data_req_sl1   (data_req_sl1),
        .data_we_sl1    (data_we_sl1),
        .data_be_sl1    (data_be_sl1),
        .data_addr_sl1  (data_addr_sl1),
        .data_wdata_sl1 (data_wdata_sl1),
        .core_busy_sl1  (core_busy_sl1),
        .instr_req_sl2  (instr_req_sl2),
        .instr_addr_sl2 (instr_addr_sl2),
        .data_req_sl2   (data_req_sl2),
        .data_we_sl2    (data_we_sl2),
        .data_be_sl2    (data_be_sl2),
        .data_addr_sl2  (data_addr_sl2),
        .data_wdata_sl2 (data_wdata_sl2),
        .core_busy_sl2  (core_busy_sl2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_match(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic we, input logic [3:0] be, input logic [31:0] da,
                               input logic [31:0] wd, input logic cb);
        instr_req_ms  = ir; instr_req_sl1  = ir; instr_req_sl2  = ir;
        instr_addr_ms = ia; instr_addr_sl1 = ia; instr_addr_sl2 = ia;
        data_req_ms   = dr; data_req_sl1   = dr; data_req_sl2   = dr;
        data_we_ms    = we; data_we_sl1    = we; data_we_sl2    = we;
        data_be_ms    = be; data_be_sl1    = be; data_be_sl2    = be;
        data_addr_ms  = da; data_addr_sl1  = da; data_addr_sl2  = da;
        data_wdata_ms = wd; data_wdata_sl1 = wd; data_wdata_sl2 = wd;
        core_busy_ms  = cb; core_busy_sl1  = cb; core_busy_sl2  = cb;
    endtask

    task automatic drive_random();
        drive_match(1'($urandom), $urandom, 1'($urandom), 1'($urandom),
                    4'($urandom), $urandom, $urandom, 1'($urandom));
    endtask

    task automatic drive_idle();
        drive_match(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Reset pulse placed between clock edges, with matched idle inputs.
    task automatic do_reset();
        drive_idle();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic check(input string name, input logic exp);
        n_tests++;
        if (fault !== exp) begin
            n_fail++;
            $display("FAIL %s: fault=%b expected=%b at %0t", name, fault, exp, $time);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_random();
        #1;
        check("reset_async", 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_random();
            data_addr_sl1 = ~data_addr_ms;
            instr_req_sl2 = ~instr_req_ms;
            tick();
        end
        check("reset_held", 1'b0);
        drive_idle();
        #2 rst = 1'b0;
        tick();
        tick();
        check("reset_released", 1'b0);
    endtask

    task automatic test_lockstep();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            drive_random();
            tick();
            seen = seen | fault;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL lockstep_1000: fault seen=%b expected=0", seen);
        end
    endtask

    task automatic test_masked();
        do_reset();
        drive_idle();
        data_addr_ms  = 32'h0000_0000;
        data_addr_sl1 = 32'h0000_0004;
        instr_addr_sl2 = 32'hDEAD_BEEF;
        tick();
        check("masked_no_req", 1'b0);
        data_req_ms = 1'b1; data_req_sl1 = 1'b1; data_req_sl2 = 1'b1;
        tick();
        check("masked_req_on", 1'b1);
        drive_idle();
        tick();
        check("masked_sticky", 1'b1);
        tick();
        check("masked_sticky2", 1'b1);
    endtask

    task automatic test_wdata();
        do_reset();
        drive_match(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1000_0000, 32'hA5A5_0000, 1'b0);
        data_wdata_sl2 = data_wdata_ms ^ 32'h0000_0020;
        tick();
        check("wdata_we0", 1'b0);
        data_we_ms = 1'b1; data_we_sl1 = 1'b1; data_we_sl2 = 1'b1;
        tick();
        check("wdata_we1", 1'b1);
    endtask

    task automatic test_fields();
        do_reset();
        drive_match(1'b1, 32'h0000_0100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        instr_addr_sl2 = 32'h8000_0100;
        tick();
        check("instr_addr_msb", 1'b1);

        do_reset();
        drive_match(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h0, 1'b0);
        data_be_sl1 = 4'b0111;
        tick();
        check("data_be", 1'b1);

        do_reset();
        drive_match(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
        data_we_sl2 = 1'b1;
        tick();
        check("data_we", 1'b1);

        do_reset();
        drive_match(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        data_req_sl2 = 1'b1;
        tick();
        check("data_req_slave_only", 1'b1);

        do_reset();
        drive_match(1'b1, 32'h40, 1'b1, 1'b1, 4'hF, 32'h80, 32'h1, 1'b1);
        instr_addr_sl1 = 32'h41;
        data_wdata_sl1 = 32'h3;
        core_busy_sl2  = 1'b0;
        tick();
        check("multi_field", 1'b1);
    endtask

    task automatic test_control();
        do_reset();
        drive_idle();
        instr_req_sl1 = 1'b1;
        tick();
        drive_idle();
        check("instr_req_pulse", 1'b1);
        tick();
        check("instr_req_sticky", 1'b1);

        do_reset();
        drive_idle();
        core_busy_sl2 = 1'b1;
        tick();
        drive_idle();
        check("core_busy_pulse", 1'b1);
        tick();
        check("core_busy_sticky", 1'b1);
    endtask

    task automatic test_reset_mid_fault();
        do_reset();
        drive_idle();
        core_busy_sl1 = 1'b1;
        tick();
        drive_idle();
        check("mid_fault_set", 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_fault_async_clear", 1'b0);
        rst = 1'b0;
        tick();
        tick();
        check("mid_fault_stays_clear", 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive_idle();
        test_reset();
        test_lockstep();
        test_masked();
        test_wdata();
        test_fields();
        test_control();
        test_reset_mid_fault();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
